// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: ALU request bundle, buffered result entry, and buffer sizing.
package alu_share_arbiter_pkg;

  localparam int unsigned XLEN              = 64;
  localparam int unsigned TRANS_ID_BITS     = 3;
  // Requester index width carried in buffered entries (default configuration: 2 requesters)
  localparam int unsigned ARB_REQ_IDX_W     = 1;
  localparam int unsigned ALU_ARB_BUF_DEPTH = 2;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    ANDL = 4'd2,
    ORL  = 4'd3,
    XORL = 4'd4,
    EQ   = 4'd5,
    NE   = 4'd6,
    LTS  = 4'd7
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    xlen_t                    operand_a;
    xlen_t                    operand_b;
    xlen_t                    imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    xlen_t                    result;
    logic                     branch;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [ARB_REQ_IDX_W-1:0] req_idx;
  } alu_arb_entry_t;

endpackage

// File: rtl/alu_res_buf.sv
// Two-entry result FIFO with synchronous flush; push is refused when full even if a pop occurs.
module alu_res_buf
  import alu_share_arbiter_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  alu_arb_entry_t data_i,
  input  logic           pop_i,
  output alu_arb_entry_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  logic [1:0]     r_count;
  logic           r_wptr;
  logic           r_rptr;
  alu_arb_entry_t r_mem [ALU_ARB_BUF_DEPTH];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == 2'(ALU_ARB_BUF_DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      for (int unsigned i = 0; i < ALU_ARB_BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      // Entries are left in place; only occupancy and pointers are cleared
      r_count <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NR_REQ requesters, results buffered in issue order.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ    = 2,
  parameter int unsigned REQ_IDX_W = (NR_REQ > 2) ? $clog2(NR_REQ) : 1
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  fu_data_t [NR_REQ-1:0]    req_data_i,
  output fu_data_t                 alu_data_o,
  input  xlen_t                    alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output xlen_t                    res_result_o,
  output logic                     res_branch_o,
  output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
  output logic [REQ_IDX_W-1:0]     res_req_idx_o
);

  logic [REQ_IDX_W-1:0]  r_rr_ptr;
  logic [2*NR_REQ-1:0]   w_rot;
  logic                  w_any;
  logic [REQ_IDX_W-1:0]  w_g;
  int unsigned           w_sum;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic [REQ_IDX_W-1:0]  w_next_rr;
  alu_arb_entry_t        w_push_entry;
  alu_arb_entry_t        w_head;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr
  assign w_rot = {req_valid_i, req_valid_i} >> r_rr_ptr;

  always_comb begin
    w_any = 1'b0;
    w_g   = r_rr_ptr;
    w_sum = 0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (!w_any && w_rot[i]) begin
        w_any = 1'b1;
        w_sum = 32'(r_rr_ptr) + i;
        if (w_sum >= NR_REQ) w_sum = w_sum - NR_REQ;
        w_g = REQ_IDX_W'(w_sum);
      end
    end
  end

  assign alu_data_o = req_data_i[w_g];
  assign w_accept   = w_any & ~w_full & ~flush_i & ~rst_i;

  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_g] = 1'b1;
  end

  assign w_next_rr = (w_g == REQ_IDX_W'(NR_REQ - 1)) ? '0 : w_g + REQ_IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= w_next_rr;
  end

  always_comb begin
    w_push_entry          = '0;
    w_push_entry.result   = alu_result_i;
    w_push_entry.branch   = alu_branch_res_i;
    w_push_entry.trans_id = req_data_i[w_g].trans_id;
    w_push_entry.req_idx  = ARB_REQ_IDX_W'(w_g);
  end

  alu_res_buf u_res_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_accept),
    .data_i  (w_push_entry),
    .pop_i   (res_ready_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign res_valid_o    = ~w_empty;
  assign res_result_o   = w_head.result;
  assign res_branch_o   = w_head.branch;
  assign res_trans_id_o = w_head.trans_id;
  assign res_req_idx_o  = REQ_IDX_W'(w_head.req_idx);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized checks of alu_share_arbiter against a queue-based reference model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready_o;
  fu_data_t [1:0]           req_data;
  fu_data_t                 alu_data;
  xlen_t                    alu_result;
  logic                     alu_br;
  logic                     res_valid_o;
  logic                     res_ready;
  xlen_t                    res_result_o;
  logic                     res_branch_o;
  logic [TRANS_ID_BITS-1:0] res_trans_id_o;
  logic [0:0]               res_req_idx_o;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NR_REQ(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_data_i       (req_data),
    .alu_data_o       (alu_data),
    .alu_result_i     (alu_result),
    .alu_branch_res_i (alu_br),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready),
    .res_result_o     (res_result_o),
    .res_branch_o     (res_branch_o),
    .res_trans_id_o   (res_trans_id_o),
    .res_req_idx_o    (res_req_idx_o)
  );

  function automatic xlen_t f_res(input fu_data_t d);
    case (d.operation)
      ADD:     return d.operand_a + d.operand_b;
      SUB:     return d.operand_a - d.operand_b;
      ANDL:    return d.operand_a & d.operand_b;
      ORL:     return d.operand_a | d.operand_b;
      XORL:    return d.operand_a ^ d.operand_b;
      default: return '0;
    endcase
  endfunction

  function automatic logic f_br(input fu_data_t d);
    case (d.operation)
      EQ:      return d.operand_a == d.operand_b;
      NE:      return d.operand_a != d.operand_b;
      LTS:     return $signed(d.operand_a) < $signed(d.operand_b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic fu_data_t mk(input fu_op op, input xlen_t a, input xlen_t b, input int tid);
    fu_data_t d;
    d.operation = op;
    d.operand_a = a;
    d.operand_b = b;
    d.imm       = '0;
    d.trans_id  = TRANS_ID_BITS'(tid);
    return d;
  endfunction

  // Behavioural ALU on the shared port
  assign alu_result = f_res(alu_data);
  assign alu_br     = f_br(alu_data);

  typedef struct {
    xlen_t r;
    logic  b;
    int    t;
    int    idx;
  } exp_t;

  exp_t q[$];
  int   rr = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge
  task automatic tick(input int dir_rdy = -1, input int dir_val = -1,
                      input longint dir_res = -1, input int dir_br = -1);
    logic [1:0] er;
    int         g;
    exp_t       e;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (!rst && !flush && q.size() < 2)
      for (int k = 0; k < 2; k++) begin
        int j;
        j = (rr + k) % 2;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready_o), 64'(er));
    chk("res_valid", 64'(res_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("res_result", res_result_o, q[0].r);
      chk("res_branch", 64'(res_branch_o), 64'(q[0].b));
      chk("res_trans_id", 64'(res_trans_id_o), 64'(q[0].t));
      chk("res_req_idx", 64'(res_req_idx_o), 64'(q[0].idx));
    end
    if (dir_rdy >= 0) chk("plan_ready", 64'(req_ready_o), 64'(dir_rdy));
    if (dir_val >= 0) chk("plan_valid", 64'(res_valid_o), 64'(dir_val));
    if (dir_res >= 0) chk("plan_result", res_result_o, 64'(dir_res));
    if (dir_br >= 0)  chk("plan_branch", 64'(res_branch_o), 64'(dir_br));
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && res_ready) void'(q.pop_front());
      if (g >= 0) begin
        e.r   = f_res(req_data[g]);
        e.b   = f_br(req_data[g]);
        e.t   = int'(req_data[g].trans_id);
        e.idx = g;
        q.push_back(e);
        rr = (g + 1) % 2;
      end
    end
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 2'b01;
    res_ready = 1'b0;
    req_data[0] = mk(ADD, 64'd5, 64'd7, 3);
    req_data[1] = mk(ADD, 64'd1, 64'd2, 1);
    @(posedge clk);
    #1;
    tick(0);
    tick(0);
    rst = 1'b0;
    req_valid = 2'b00;
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_result", res_result_o, 64'd0);
    chk("rst_branch", 64'(res_branch_o), 64'd0);
    chk("rst_trans_id", 64'(res_trans_id_o), 64'd0);
    chk("rst_req_idx", 64'(res_req_idx_o), 64'd0);

    // Single op from requester 0
    req_valid = 2'b01;
    res_ready = 1'b1;
    tick(1, 0);
    req_valid = 2'b00;
    tick(0, 1, 12);
    tick(0, 0);

    // Requester 1 op returns the pointer to 0, then round-robin with both valid
    req_valid = 2'b10;
    tick(2);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      req_data[0] = mk(ADD, 64'(100 + c), 64'd1, c);
      req_data[1] = mk(SUB, 64'(200 + c), 64'd1, 4 + c);
      tick((c % 2 == 0) ? 1 : 2, 1);
    end
    req_valid = 2'b00;
    tick(0, 1, 203 - 1);
    req_valid = 2'b11;
    tick(1, 0);
    req_valid = 2'b00;
    tick(0, 1);

    // Back-pressure on requester 1
    res_ready = 1'b0;
    req_valid = 2'b10;
    req_data[1] = mk(SUB, 64'd10, 64'd3, 1);
    tick(2, 0);
    req_data[1] = mk(XORL, 64'hF, 64'h3, 2);
    tick(2, 1, 7);
    req_data[1] = mk(ADD, 64'd1, 64'd1, 4);
    tick(0, 1, 7);
    tick(0, 1, 7);
    res_ready = 1'b1;
    tick(0, 1, 7);
    tick(2, 1, 'hC);
    req_valid = 2'b00;
    tick(0, 1, 2);
    tick(0, 0);

    // Branch outcomes
    req_valid = 2'b01;
    req_data[0] = mk(EQ, 64'h55, 64'h55, 5);
    tick(-1, 0);
    req_data[0] = mk(NE, 64'h55, 64'h55, 6);
    tick(-1, 1, -1, 1);
    req_valid = 2'b00;
    tick(0, 1, -1, 0);

    // Flush with a full buffer; round-robin pointer survives the flush
    res_ready = 1'b0;
    req_valid = 2'b01;
    req_data[0] = mk(ORL, 64'h30, 64'h03, 1);
    tick(1);
    tick(1);
    flush = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    tick(0, 1);
    flush = 1'b0;
    tick(2, 0);
    req_valid = 2'b00;
    tick(0, 1);

    // Reset mid-stream with two buffered entries
    res_ready = 1'b0;
    req_valid = 2'b01;
    tick(1);
    tick(1);
    rst = 1'b1;
    tick(0, 1);
    rst = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b1;
    tick(1, 0);
    req_valid = 2'b10;
    req_data[1] = mk(ANDL, 64'hFF, 64'h0F, 7);
    tick(2, 1);
    req_valid = 2'b00;
    tick(0, 1, 'h0F);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++)
        req_data[r] = mk(fu_op'($urandom_range(0, 7)),
                         {$urandom, $urandom}, {$urandom, $urandom},
                         int'($urandom_range(0, 7)));
      req_valid = 2'($urandom_range(0, 3));
      res_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
